// File: rtl/multicycle_alu.sv
// multicycle_alu: WIDTH-bit ALU evaluated SLICE bits per clock, LSB first,
// with a registered carry between slices and valid/ready on both sides.
// Optional feature macro: MULTICYCLE_ALU_BACK2BACK_EN. When it is defined,
// a new request may be accepted on the same edge as the output handshake.
`timescale 1ns/1ps
module multicycle_alu #(
    parameter int WIDTH = 128,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       opsel,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("multicycle_alu: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bitwise operations for mode=0, evaluated one slice at a time
    function automatic logic [SLICE-1:0] logic_slice(input logic [2:0]       sel,
                                                     input logic [SLICE-1:0] a,
                                                     input logic [SLICE-1:0] b);
        logic [SLICE-1:0] r;
        case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~a;
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a | b);
            3'b110:  r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d, z_q, z_d, o_q, o_d, s_q, s_d;
    // Operands are stored already in A + B' + cin form for arithmetic ops
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       opsel_q, opsel_d;
    logic             mode_q, mode_d;

    logic [SLICE-1:0] a_s, b_s, slice_res;
    logic [SLICE:0]   sum_ext;
    logic             cin_msb;
    logic             load;

    // Current slice datapath: adder for arithmetic, bitwise unit for logic
    always_comb begin
        a_s       = a_q[idx_q*SLICE +: SLICE];
        b_s       = b_q[idx_q*SLICE +: SLICE];
        sum_ext   = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the sum bit and its operands
        cin_msb   = sum_ext[SLICE-1] ^ a_s[SLICE-1] ^ b_s[SLICE-1];
        slice_res = mode_q ? sum_ext[SLICE-1:0] : logic_slice(opsel_q, a_s, b_s);
    end

    // Next-state, handshake outputs and operand capture
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        result_d  = result_q;
        c_d       = c_q;
        z_d       = z_q;
        o_d       = o_q;
        s_d       = s_q;
        a_d       = a_q;
        b_d       = b_q;
        opsel_d   = opsel_q;
        mode_d    = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) load = 1'b1;
            end
            S_CALC: begin
                result_d[idx_q*SLICE +: SLICE] = slice_res;
                carry_d = mode_q & sum_ext[SLICE];
                zero_d  = zero_q & (slice_res == '0);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    c_d     = mode_q & sum_ext[SLICE];
                    z_d     = zero_q & (slice_res == '0);
                    o_d     = mode_q & (cin_msb ^ sum_ext[SLICE]);
                    s_d     = slice_res[SLICE-1];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
`ifdef MULTICYCLE_ALU_BACK2BACK_EN
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) load = 1'b1;
                    else          state_d = S_IDLE;
                end
`else
                if (out_ready) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_CALC;
            idx_d   = '0;
            zero_d  = 1'b1;
            opsel_d = opsel;
            mode_d  = mode;
            a_d     = op1;
            b_d     = op2;
            carry_d = 1'b0;
            if (mode) begin
                case (opsel)
                    3'b000: ;
                    3'b001: begin b_d = ~op2; carry_d = 1'b1; end
                    3'b010: begin b_d = '0;   carry_d = 1'b1; end
                    3'b011: begin b_d = '1; end
                    3'b100: begin a_d = '0;   b_d = ~op2; carry_d = 1'b1; end
                    // Reserved codes reduce to 0 + 0 + 0: result 0, z=1, other flags 0
                    default: begin a_d = '0; b_d = '0; end
                endcase
            end
        end
    end

    // Control and visible result/flag registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
            s_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            o_q      <= o_d;
            s_q      <= s_d;
        end
    end

    // Captured operands; only meaningful after an accept, so no reset
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        opsel_q <= opsel_d;
        mode_q  <= mode_d;
    end

    assign result = result_q;
    assign c_flag = c_q;
    assign z_flag = z_q;
    assign o_flag = o_q;
    assign s_flag = s_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu: a 128/8 instance and a 32/32 instance,
// randomized and directed operations checked against a behavioural model.
`timescale 1ns/1ps
module tb_multicycle_alu;

    localparam int W  = 128;
    localparam int S  = 8;
    localparam int N  = W / S;
    localparam int WS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready, mode;
    logic [W-1:0]   op1, op2, result;
    logic [2:0]     opsel;
    logic           c_flag, z_flag, o_flag, s_flag;

    logic           w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_mode;
    logic [WS-1:0]  w_op1, w_op2, w_result;
    logic [2:0]     w_opsel;
    logic           w_c_flag, w_z_flag, w_o_flag, w_s_flag;

    int checks   = 0;
    int failures = 0;

    multicycle_alu #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag)
    );

    multicycle_alu #(.WIDTH(WS), .SLICE(WS)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .op1(w_op1), .op2(w_op2), .opsel(w_opsel), .mode(w_mode),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
        .c_flag(w_c_flag), .z_flag(w_z_flag), .o_flag(w_o_flag), .s_flag(w_s_flag)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operation table; flags {c,z,o,s}
    function automatic void ref_alu(input int w, input logic [127:0] a, input logic [127:0] b,
                                    input logic [2:0] sel, input logic md,
                                    output logic [127:0] r, output logic [3:0] f);
        logic [127:0] mask, aa, bb;
        logic [128:0] sum;
        logic ci, c, o, rsv;
        mask = (w >= 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        a = a & mask;
        b = b & mask;
        c = 1'b0; o = 1'b0; r = '0; rsv = 1'b0;
        aa = a; bb = b; ci = 1'b0;
        if (md) begin
            case (sel)
                3'd0: ;
                3'd1: begin bb = ~b & mask; ci = 1'b1; end
                3'd2: begin bb = '0; ci = 1'b1; end
                3'd3: bb = mask;
                3'd4: begin aa = '0; bb = ~b & mask; ci = 1'b1; end
                default: rsv = 1'b1;
            endcase
            if (!rsv) begin
                sum = {1'b0, aa} + {1'b0, bb} + {128'd0, ci};
                r   = sum[127:0] & mask;
                c   = sum[w];
                o   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
            end
        end else begin
            case (sel)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd3: r = ~a;
                3'd4: r = ~(a & b);
                3'd5: r = ~(a | b);
                3'd6: r = ~(a ^ b);
                default: r = a;
            endcase
            r = r & mask;
        end
        f = {c, (r == '0), o, r[w-1]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request to the wide instance for one accept edge, then scramble inputs
    task automatic issue_big(input logic [127:0] a, input logic [127:0] b,
                             input logic [2:0] sel, input logic md);
        op1 = a; op2 = b; opsel = sel; mode = md; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op1 = rand128(); op2 = rand128(); opsel = 3'($urandom_range(0, 7)); mode = ~md;
    endtask

    task automatic wait_big(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_big(input logic [127:0] a, input logic [127:0] b,
                           input logic [2:0] sel, input logic md);
        logic [127:0] er;
        logic [3:0]   ef;
        int           lat;
        ref_alu(W, a, b, sel, md, er, ef);
        check_val("big_idle_in_ready", 128'(in_ready), 128'd1);
        issue_big(a, b, sel, md);
        check_val("big_calc_in_ready", 128'(in_ready), 128'd0);
        wait_big(lat);
        check_val("big_latency", 128'(lat), 128'(N));
        check_val("big_result", result, er);
        check_val("big_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'(ef));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("big_post_hs_valid", 128'(out_valid), 128'd0);
        check_val("big_idle_hold", result, er);
    endtask

    task automatic run_small(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] sel, input logic md);
        logic [127:0] er;
        logic [3:0]   ef;
        int           lat;
        ref_alu(WS, 128'(a), 128'(b), sel, md, er, ef);
        w_op1 = a; w_op2 = b; w_opsel = sel; w_mode = md; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        w_op1 = $urandom; w_op2 = $urandom;
        lat = 0;
        while (!w_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check_val("small_latency", 128'(lat), 128'd1);
        check_val("small_result", 128'(w_result), er);
        check_val("small_flags", 128'({w_c_flag, w_z_flag, w_o_flag, w_s_flag}), 128'(ef));
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
        check_val("small_post_hs_valid", 128'(w_out_valid), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] er, held_r;
        logic [3:0]   ef, held_f;
        int           lat;
        int           seen;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0; opsel = '0; mode = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_op1 = '0; w_op2 = '0; w_opsel = '0; w_mode = 1'b0;
        repeat (2) tick();
        check_val("rst_in_ready", 128'(in_ready), 128'd1);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_result", result, 128'd0);
        check_val("rst_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'd0);
        check_val("rst_small_result", 128'(w_result), 128'd0);
        rst = 1'b0;
        tick();

        // ADD all-ones + 1 wraps to zero with carry out
        run_big({128{1'b1}}, 128'd1, 3'b000, 1'b1);
        check_val("add_wrap_result", result, 128'd0);
        check_val("add_wrap_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'(4'b1100));

        // SUB max-positive minus -1 overflows into the sign bit
        run_big({1'b0, {127{1'b1}}}, {128{1'b1}}, 3'b001, 1'b1);
        check_val("sub_ovf_result", result, {1'b1, 127'd0});
        check_val("sub_ovf_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'(4'b0011));

        run_big({16{8'hA5}}, {16{8'hA5}}, 3'b010, 1'b0);
        check_val("xor_self_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'(4'b0100));
        run_big(128'd0, rand128(), 3'b011, 1'b0);
        check_val("not_zero_result", result, {128{1'b1}});
        check_val("not_zero_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'(4'b0001));

        // Output stall: result stable, request while stalled is not taken
        held_r = rand128();
        ref_alu(W, held_r, 128'd77, 3'b000, 1'b1, er, ef);
        issue_big(held_r, 128'd77, 3'b000, 1'b1);
        wait_big(lat);
        check_val("stall_latency", 128'(lat), 128'(N));
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            op1 = rand128(); op2 = rand128(); opsel = 3'b001; mode = 1'b1;
            check_val("stall_in_ready", 128'(in_ready), 128'd0);
            tick();
            check_val("stall_out_valid", 128'(out_valid), 128'd1);
            check_val("stall_result", result, er);
            check_val("stall_flags", 128'({c_flag, z_flag, o_flag, s_flag}), 128'(ef));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("stall_release_valid", 128'(out_valid), 128'd0);
        check_val("stall_release_in_ready", 128'(in_ready), 128'd1);

`ifdef MULTICYCLE_ALU_BACK2BACK_EN
        // Output handshake and new accept on the same edge
        issue_big(128'd100, 128'd23, 3'b000, 1'b1);
        wait_big(lat);
        check_val("b2b_first_result", result, 128'd123);
        ref_alu(W, 128'd9, 128'd4, 3'b001, 1'b1, er, ef);
        check_val("b2b_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        op1 = 128'd9; op2 = 128'd4; opsel = 3'b001; mode = 1'b1; in_valid = 1'b1;
        check_val("b2b_in_ready_follow", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_val("b2b_second_calc", 128'(in_ready), 128'd0);
        wait_big(lat);
        check_val("b2b_second_latency", 128'(lat), 128'(N));
        check_val("b2b_second_result", result, er);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        // Reset while the eighth slice is in flight discards the operation
        issue_big(rand128(), rand128(), 3'b000, 1'b1);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_in_ready", 128'(in_ready), 128'd1);
        check_val("midrst_out_valid", 128'(out_valid), 128'd0);
        check_val("midrst_result", result, 128'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (out_valid) seen = 1;
        end
        check_val("midrst_no_output", 128'(seen), 128'd0);
        run_big(128'd5, 128'd3, 3'b000, 1'b1);
        check_val("midrst_add_result", result, 128'd8);

        // Randomized operations with some boundary operands mixed in
        for (int i = 0; i < 24; i++) begin
            logic [127:0] a, b;
            a = rand128();
            b = rand128();
            case (i % 6)
                1: a = {128{1'b1}};
                2: b = '0;
                3: b = {128{1'b1}};
                4: a = {1'b1, 127'd0};
                default: ;
            endcase
            run_big(a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // Single-slice instance
        run_small(32'd0, $urandom, 3'b011, 1'b1);
        check_val("small_dec_result", 128'(w_result), 128'hFFFF_FFFF);
        check_val("small_dec_flags", 128'({w_c_flag, w_z_flag, w_o_flag, w_s_flag}), 128'(4'b0001));
        run_small($urandom, $urandom, 3'b101, 1'b1);
        check_val("small_rsv_result", 128'(w_result), 128'd0);
        check_val("small_rsv_z", 128'(w_z_flag), 128'd1);
        for (int i = 0; i < 12; i++) begin
            run_small($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
